// File: rtl/mem_block_mover.sv
// mem_block_mover: memory-port bus master that copies a block of words or fills a range
// with a constant, one read/write pair per copied word.
module mem_block_mover #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] pattern,
   input  logic              abort,
   output logic              memRead,
   output logic              memWrite,
   output logic [ADDR_W-1:0] adr,
   output logic [DATA_W-1:0] writeData,
   input  logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  words_done
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [LEN_W-1:0] rem_q, rem_d, cnt_q, cnt_d;
   logic [DATA_W-1:0] buf_q, buf_d, fill_q, fill_d;
   logic mode_q, mode_d;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         fill_q  <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         mode_q  <= mode_d;
      end
   end
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      fill_d  = fill_q;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE: if (start) begin
            src_d   = src;
            dst_d   = dst;
            rem_d   = len;
            fill_d  = pattern;
            mode_d  = mode;
            cnt_d   = '0;
            state_d = (len == '0) ? DONE : mode ? WR : RD;
         end
         RD: begin
            buf_d   = data;
            state_d = abort ? IDLE : WR;
         end
         // the write in this cycle commits even on abort, so it is always counted
         WR: begin
            src_d   = src_q + 1'b1;
            dst_d   = dst_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = abort ? IDLE : (rem_q == LEN_W'(1)) ? DONE : mode_q ? WR : RD;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign memRead    = (state_q == RD);
   assign memWrite   = (state_q == WR);
   assign busy       = memRead | memWrite;
   assign done       = (state_q == DONE);
   assign adr        = memRead ? src_q : memWrite ? dst_q : '0;
   assign writeData  = memWrite ? (mode_q ? fill_q : buf_q) : '0;
   assign words_done = cnt_q;
endmodule

// File: tb/tb_mem_block_mover.sv
// tb_mem_block_mover: directed scenarios against a behavioural single-port memory.
module tb_mem_block_mover;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, mode = 1'b0, abort = 1'b0;
   logic [12:0] src = '0, dst = '0;
   logic [10:0] len = '0;
   logic [15:0] pattern = '0;
   logic memRead, memWrite, busy, done;
   logic [12:0] adr;
   logic [15:0] writeData, data;
   logic [10:0] words_done;
   logic [15:0] mem [0:8191];
   logic ld_en = 1'b0;
   logic [12:0] ld_adr = '0;
   logic [15:0] ld_dat = '0;
   int checks = 0, errors = 0;
   int done_cyc, done_n, rd_n, wr_n;
   logic both_hi;
   logic [12:0] rd_a [0:15];
   logic [12:0] wr_a [0:15];

   mem_block_mover dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
      .len(len), .pattern(pattern), .abort(abort), .memRead(memRead),
      .memWrite(memWrite), .adr(adr), .writeData(writeData), .data(data),
      .busy(busy), .done(done), .words_done(words_done)
   );

   always #5 clk = ~clk;
   assign data = mem[adr];
   always @(posedge clk) begin
      if (memWrite) mem[adr] <= writeData;
      else if (ld_en) mem[ld_adr] <= ld_dat;
   end

   task automatic poke(input logic [12:0] a, input logic [15:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_adr = a; ld_dat = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Start sampled at edge 0; observes cycles 1..ncyc at the falling edge.
   // Raises abort during the ab-th write cycle when ab > 0.
   task automatic launch(input logic m, input logic [12:0] s, input logic [12:0] d,
                         input logic [10:0] l, input logic [15:0] p, input int ab, input int ncyc);
      @(negedge clk);
      mode = m; src = s; dst = d; len = l; pattern = p; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_cyc = 0; done_n = 0; rd_n = 0; wr_n = 0; both_hi = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         if (c > 1) begin
            @(negedge clk);
            abort = 1'b0;
         end
         if (memRead && memWrite) both_hi = 1'b1;
         if (memRead && rd_n < 16) begin rd_a[rd_n] = adr; rd_n++; end
         if (memWrite && wr_n < 16) begin
            wr_a[wr_n] = adr; wr_n++;
            if (wr_n == ab) abort = 1'b1;
         end
         if (done) begin
            done_n++;
            if (done_cyc == 0) done_cyc = c;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (memRead !== 1'b0) begin errors++; $display("FAIL reset_memRead got %b exp 0", memRead); end
      checks++; if (memWrite !== 1'b0) begin errors++; $display("FAIL reset_memWrite got %b exp 0", memWrite); end
      checks++; if (adr !== 13'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", adr); end
      checks++; if (writeData !== 16'h0) begin errors++; $display("FAIL reset_writeData got %h exp 0", writeData); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (words_done !== 11'd0) begin errors++; $display("FAIL reset_words_done got %0d exp 0", words_done); end
      rst = 1'b0;
   endtask

   task automatic test_copy;
      poke(13'd0, 16'h000A); poke(13'd1, 16'h000B); poke(13'd2, 16'h000C); poke(13'd3, 16'h000D);
      poke(13'd104, 16'h7777);
      launch(1'b0, 13'd0, 13'd100, 11'd4, 16'h0, 0, 10);
      checks++; if (done_cyc !== 9) begin errors++; $display("FAIL copy_done_cycle got %0d exp 9", done_cyc); end
      checks++; if (done_n !== 1) begin errors++; $display("FAIL copy_done_pulses got %0d exp 1", done_n); end
      checks++; if (both_hi !== 1'b0) begin errors++; $display("FAIL copy_strobe_overlap got %b exp 0", both_hi); end
      checks++; if (rd_n !== 4) begin errors++; $display("FAIL copy_reads got %0d exp 4", rd_n); end
      checks++; if (wr_n !== 4) begin errors++; $display("FAIL copy_writes got %0d exp 4", wr_n); end
      checks++; if (mem[100] !== 16'h000A) begin errors++; $display("FAIL copy_mem100 got %h exp 000a", mem[100]); end
      checks++; if (mem[101] !== 16'h000B) begin errors++; $display("FAIL copy_mem101 got %h exp 000b", mem[101]); end
      checks++; if (mem[102] !== 16'h000C) begin errors++; $display("FAIL copy_mem102 got %h exp 000c", mem[102]); end
      checks++; if (mem[103] !== 16'h000D) begin errors++; $display("FAIL copy_mem103 got %h exp 000d", mem[103]); end
      checks++; if (mem[104] !== 16'h7777) begin errors++; $display("FAIL copy_mem104 got %h exp 7777", mem[104]); end
      checks++; if (words_done !== 11'd4) begin errors++; $display("FAIL copy_words_done got %0d exp 4", words_done); end
   endtask

   task automatic test_fill;
      poke(13'd203, 16'h1234);
      launch(1'b1, 13'd0, 13'd200, 11'd3, 16'hBEEF, 0, 6);
      checks++; if (done_cyc !== 4) begin errors++; $display("FAIL fill_done_cycle got %0d exp 4", done_cyc); end
      checks++; if (rd_n !== 0) begin errors++; $display("FAIL fill_reads got %0d exp 0", rd_n); end
      checks++; if (wr_n !== 3) begin errors++; $display("FAIL fill_writes got %0d exp 3", wr_n); end
      checks++; if (mem[200] !== 16'hBEEF) begin errors++; $display("FAIL fill_mem200 got %h exp beef", mem[200]); end
      checks++; if (mem[201] !== 16'hBEEF) begin errors++; $display("FAIL fill_mem201 got %h exp beef", mem[201]); end
      checks++; if (mem[202] !== 16'hBEEF) begin errors++; $display("FAIL fill_mem202 got %h exp beef", mem[202]); end
      checks++; if (mem[203] !== 16'h1234) begin errors++; $display("FAIL fill_mem203 got %h exp 1234", mem[203]); end
      checks++; if (words_done !== 11'd3) begin errors++; $display("FAIL fill_words_done got %0d exp 3", words_done); end
   endtask

   task automatic test_len0;
      launch(1'b0, 13'd5, 13'd50, 11'd0, 16'h0, 0, 3);
      checks++; if (done_cyc !== 1) begin errors++; $display("FAIL len0_done_cycle got %0d exp 1", done_cyc); end
      checks++; if (rd_n + wr_n !== 0) begin errors++; $display("FAIL len0_strobes got %0d exp 0", rd_n + wr_n); end
      checks++; if (words_done !== 11'd0) begin errors++; $display("FAIL len0_words_done got %0d exp 0", words_done); end
   endtask

   task automatic test_wrap;
      poke(13'h1FFF, 16'h1111); poke(13'h0000, 16'h2222);
      launch(1'b0, 13'h1FFF, 13'h1FFE, 11'd2, 16'h0, 0, 6);
      checks++; if (rd_a[1] !== 13'h0000) begin errors++; $display("FAIL wrap_rd_adr got %h exp 0000", rd_a[1]); end
      checks++; if (wr_a[1] !== 13'h1FFF) begin errors++; $display("FAIL wrap_wr_adr got %h exp 1fff", wr_a[1]); end
      checks++; if (mem[13'h1FFE] !== 16'h1111) begin errors++; $display("FAIL wrap_mem1ffe got %h exp 1111", mem[13'h1FFE]); end
      checks++; if (mem[13'h1FFF] !== 16'h2222) begin errors++; $display("FAIL wrap_mem1fff got %h exp 2222", mem[13'h1FFF]); end
      checks++; if (done_cyc !== 5) begin errors++; $display("FAIL wrap_done_cycle got %0d exp 5", done_cyc); end
   endtask

   task automatic test_overlap;
      poke(13'd0, 16'd1); poke(13'd1, 16'd2); poke(13'd2, 16'd3); poke(13'd3, 16'd4);
      launch(1'b0, 13'd0, 13'd1, 11'd3, 16'h0, 0, 8);
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem[i] !== 16'd1) begin errors++; $display("FAIL overlap_mem%0d got %h exp 0001", i, mem[i]); end
      end
   endtask

   task automatic test_abort;
      poke(13'd400, 16'hEEEE); poke(13'd401, 16'hEEEE); poke(13'd402, 16'hEEEE);
      launch(1'b0, 13'd0, 13'd400, 11'd5, 16'h0, 2, 4);
      start = 1'b1; mode = 1'b1; dst = 13'd300; len = 11'd1; pattern = 16'h5555;
      @(negedge clk);
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0 || done_n !== 0) begin errors++; $display("FAIL abort_no_done got %b/%0d exp 0/0", done, done_n); end
      checks++; if (words_done !== 11'd2) begin errors++; $display("FAIL abort_words_done got %0d exp 2", words_done); end
      checks++; if (wr_n !== 2) begin errors++; $display("FAIL abort_writes got %0d exp 2", wr_n); end
      checks++; if (mem[401] !== 16'd1) begin errors++; $display("FAIL abort_mem401 got %h exp 0001", mem[401]); end
      checks++; if (mem[402] !== 16'hEEEE) begin errors++; $display("FAIL abort_mem402 got %h exp eeee", mem[402]); end
      @(negedge clk);
      start = 1'b0;
      checks++; if (memWrite !== 1'b1 || adr !== 13'd300) begin errors++; $display("FAIL abort_restart got %b/%h exp 1/012c", memWrite, adr); end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_restart_done got %b exp 1", done); end
      checks++; if (mem[300] !== 16'h5555) begin errors++; $display("FAIL abort_mem300 got %h exp 5555", mem[300]); end
   endtask

   task automatic test_async_reset;
      poke(13'd600, 16'h3333);
      launch(1'b0, 13'd0, 13'd600, 11'd4, 16'h0, 0, 1);
      checks++; if (memRead !== 1'b1) begin errors++; $display("FAIL arst_pre_rd got %b exp 1", memRead); end
      #1 rst = 1'b1;
      #1;
      checks++; if (memRead !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arst_strobe got %b/%b exp 0/0", memRead, busy); end
      checks++; if (adr !== 13'h0) begin errors++; $display("FAIL arst_adr got %h exp 0", adr); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (mem[600] !== 16'h3333) begin errors++; $display("FAIL arst_mem600 got %h exp 3333", mem[600]); end
      launch(1'b1, 13'd0, 13'd500, 11'd2, 16'hA5A5, 0, 4);
      checks++; if (done_cyc !== 3) begin errors++; $display("FAIL arst_fill_done got %0d exp 3", done_cyc); end
      checks++; if (mem[500] !== 16'hA5A5 || mem[501] !== 16'hA5A5) begin errors++; $display("FAIL arst_fill_mem got %h/%h exp a5a5", mem[500], mem[501]); end
      checks++; if (words_done !== 11'd2) begin errors++; $display("FAIL arst_words_done got %0d exp 2", words_done); end
   endtask

   initial begin
      test_reset;
      test_copy;
      test_fill;
      test_len0;
      test_wrap;
      test_overlap;
      test_abort;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
